data_sram_arbiter: RTL and testbench
====================================

Name: data_sram_arbiter

Overview:
- Shares the single data SRAM port between two requesters.
  - Port 0: the MEM-stage load/store path.
  - Port 1: a secondary master, e.g. uncached/debug access.
- Sequences the SRAM's address/data handshake (addr_ok / data_ok, variable latency) through a 4-state FSM.
- Raises a stall request to the pipeline stall controller while port 0 is outstanding.
- Includes a watchdog that aborts transactions the SRAM never completes.

Parameters:
TIMEOUT, 255, cycles spent in ADDR+DATA before abort (1..65535)
P0_FIRST, 1, on simultaneous requests after reset, port 0 wins the first arbitration

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
m0_req  in  1  port-0 request, level; held with payload until m0_done
m0_wr  in  1  1 = store, 0 = load
m0_wstrb  in  4  byte enables for stores
m0_addr  in  32  byte address
m0_wdata  in  32  store data
m0_done  out  1  one-cycle completion pulse
m0_err  out  1  with m0_done: transaction aborted by watchdog
m0_rdata  out  32  load data, valid while m0_done=1
m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata, m1_done, m1_err, m1_rdata  same as port 0, for port 1
sram_req  out  1  SRAM request
sram_wr  out  1  SRAM write
sram_wstrb  out  4  SRAM byte enables
sram_addr  out  32  SRAM address
sram_wdata  out  32  SRAM write data
sram_addr_ok  in  1  SRAM accepted address this cycle
sram_data_ok  in  1  SRAM read data / write ack this cycle
sram_rdata  in  32  SRAM read data
stallreq_mem  out  1  to stall controller: hold pipeline, port 0 pending

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP. An owner bit records the granted port. A last bit records the previous winner.
- Reset (rst=0, immediate):
  - state=IDLE; all sram_* = 0; mX_done = mX_err = 0; mX_rdata = 0.
  - owner=0; last = P0_FIRST ? 1 : 0; watchdog counter = 0.
  - Reset mid-transaction abandons it with no done pulse. Requesters are reset by the same rst.
- IDLE:
  - Only one req high: grant that port.
  - Both high: round-robin, grant the port that is not `last`.
  - On grant: register wr/wstrb/addr/wdata into sram_* regs, set owner, last=owner, go to ADDR.
  - Writes: sram_wstrb = latched wstrb. Loads: sram_wstrb = 0.
- ADDR:
  - sram_req=1 with the latched payload, stable until addr_ok.
  - sram_addr_ok=1: drop sram_req next cycle, go to DATA.
  - data_ok is not expected in ADDR and is ignored.
- DATA:
  - sram_req=0. Wait for sram_data_ok=1.
  - Capture sram_rdata (loads; writes capture 0), go to RESP.
- RESP (exactly one cycle):
  - m{owner}_done=1, m{owner}_rdata = captured data, err as set. Next state IDLE.
  - Requester drops or changes req on the same edge. A req still high in IDLE is a new transaction.
- Latency:
  - Minimum is 4 cycles from req sampled in IDLE to done (IDLE, ADDR, DATA, RESP), with addr_ok and data_ok each arriving on the first possible cycle.
  - Back-to-back transactions occupy the port for 4 cycles each, with no idle gap.
- Watchdog:
  - Counter clears on entry to ADDR and increments each cycle in ADDR/DATA.
  - When the count reaches TIMEOUT: sram_req=0, go to RESP with err=1, rdata=0.
  - A late data_ok for the aborted transaction is ignored.
- Stall: stallreq_mem = m0_req & ~(state==RESP & owner==0). This is combinational and deasserts in the m0_done cycle.
- Fairness: with both ports requesting continuously, grants strictly alternate. Neither port waits for more than one foreign transaction.
- Non-granted port's done/err stay 0. mX_rdata holds its last value when done=0.

Test Plan:
- Port-0 load, addr 0x100; addr_ok in ADDR cycle 1; data_ok 0xDEADBEEF after 2 DATA cycles -> m0_done 1 cycle, m0_rdata=0xDEADBEEF; stallreq_mem high from req until the done cycle.
- Port-1 store, wstrb=0x3, addr 0x204, wdata 0x1234 -> sram_req/wr=1, sram_wstrb=0x3 held until addr_ok; m1_done after data_ok; m1_rdata=0; stallreq_mem stays 0.
- Both ports request continuously from reset (P0_FIRST=1) -> grant order 0,1,0,1; each transaction exactly 4 cycles with zero-wait SRAM.
- SRAM never asserts data_ok, TIMEOUT=8 -> after 8 ADDR+DATA cycles, done=1 with err=1, rdata=0; a data_ok arriving 3 cycles later -> no pulse, FSM stays IDLE.
- rst driven low during DATA -> sram_req, done, stallreq_mem go low immediately without a clock edge; after release, first request completes normally.
- addr_ok held low for 5 cycles -> sram_addr/wdata/wstrb stable throughout, sram_req stays 1 until the cycle after addr_ok.

Source files
------------

// File: rtl/data_sram_arbiter.sv
// data_sram_arbiter
//   Shares the single data SRAM port between the MEM-stage load/store path
//   (port 0) and a secondary master (port 1). A 4-state FSM sequences the
//   SRAM address/data handshake, a watchdog aborts transactions the SRAM
//   never completes, and a stall request holds the pipeline while port 0 is
//   outstanding.
//
// Ports
//   clk, rst               clock, asynchronous active-low reset
//   mX_req/wr/wstrb/addr/wdata   requester X command, held until mX_done
//   mX_done/err/rdata      completion pulse, watchdog abort flag, load data
//   sram_req/wr/wstrb/addr/wdata sram_addr_ok/data_ok/rdata   SRAM side
//   stallreq_mem           port 0 pending, to the pipeline stall controller
module data_sram_arbiter #(
   parameter int unsigned TIMEOUT  = 255,
   parameter bit          P0_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_done,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_done,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        sram_req,
   output logic        sram_wr,
   output logic [3:0]  sram_wstrb,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic        sram_addr_ok,
   input  logic        sram_data_ok,
   input  logic [31:0] sram_rdata,
   output logic        stallreq_mem
);

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [15:0] wd_cnt_q, wd_cnt_d;
   logic        err_q, err_d;
   logic        grant;
   logic        load_payload;
   logic        capture;
   logic [31:0] cap_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         last_q   <= P0_FIRST;
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      wd_cnt_d     = wd_cnt_q;
      err_d        = err_q;
      grant        = 1'b0;
      load_payload = 1'b0;
      capture      = 1'b0;
      cap_data     = '0;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               // Contention goes to the port that did not win last time.
               grant        = (m0_req && m1_req) ? ~last_q : m1_req;
               owner_d      = grant;
               last_d       = grant;
               wd_cnt_d     = '0;
               err_d        = 1'b0;
               load_payload = 1'b1;
               state_d      = ADDR;
            end
         end
         ADDR: begin
            // The watchdog wins over a same-cycle addr_ok; the late data_ok
            // that follows lands in IDLE and is dropped.
            if (wd_cnt_q == WD_LAST) begin
               err_d   = 1'b1;
               capture = 1'b1;
               state_d = RESP;
            end else begin
               wd_cnt_d = wd_cnt_q + 16'd1;
               if (sram_addr_ok) state_d = DATA;
            end
         end
         DATA: begin
            // A data_ok in the final watchdog cycle still completes normally.
            if (sram_data_ok) begin
               capture  = 1'b1;
               cap_data = sram_wr ? '0 : sram_rdata;
               state_d  = RESP;
            end else if (wd_cnt_q == WD_LAST) begin
               err_d   = 1'b1;
               capture = 1'b1;
               state_d = RESP;
            end else begin
               wd_cnt_d = wd_cnt_q + 16'd1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sram_wr    <= 1'b0;
         sram_wstrb <= '0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         if (load_payload) begin
            sram_wr    <= grant ? m1_wr : m0_wr;
            sram_wstrb <= grant ? (m1_wr ? m1_wstrb : 4'h0)
                                : (m0_wr ? m0_wstrb : 4'h0);
            sram_addr  <= grant ? m1_addr  : m0_addr;
            sram_wdata <= grant ? m1_wdata : m0_wdata;
         end
         // Each port's rdata register doubles as the capture register, so it
         // holds the last result once done drops.
         if (capture) begin
            if (owner_q) m1_rdata <= cap_data;
            else         m0_rdata <= cap_data;
         end
      end
   end

   assign sram_req     = (state_q == ADDR);
   assign m0_done      = (state_q == RESP) && !owner_q;
   assign m1_done      = (state_q == RESP) &&  owner_q;
   assign m0_err       = m0_done && err_q;
   assign m1_err       = m1_done && err_q;
   assign stallreq_mem = m0_req && !m0_done;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Testbench for data_sram_arbiter: two requester tasks, a behavioural SRAM
// with configurable handshake latency, and a scoreboard monitor that checks
// every completion against expectations queued at issue time.
module tb_data_sram_arbiter;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_done, m0_err, m1_done, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        sram_req, sram_wr;
   logic [3:0]  sram_wstrb;
   logic [31:0] sram_addr, sram_wdata;
   logic        sram_addr_ok, sram_data_ok;
   logic [31:0] sram_rdata;
   logic        stallreq_mem;

   data_sram_arbiter #(.TIMEOUT(TO), .P0_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .sram_req(sram_req), .sram_wr(sram_wr), .sram_wstrb(sram_wstrb),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok),
      .sram_rdata(sram_rdata), .stallreq_mem(stallreq_mem)
   );

   initial forever #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] rdata; logic err; } exp_t;
   typedef struct { int port; int unsigned cyc; } done_t;
   exp_t  exp_q0[$];
   exp_t  exp_q1[$];
   done_t dlog[$];
   logic [31:0] ref_mem  [int unsigned];
   logic [31:0] sram_mem [int unsigned];

   function automatic logic [31:0] init_word(input int unsigned wa);
      return {wa[15:0], ~wa[15:0]} ^ 32'h3C3C_C3C3;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] ws);
      logic [31:0] r = old;
      for (int unsigned b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_rd(input int unsigned wa);
      return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
   endfunction

   function automatic logic [31:0] sram_rd(input int unsigned wa);
      return sram_mem.exists(wa) ? sram_mem[wa] : init_word(wa);
   endfunction

   function automatic int unsigned last_done(input int p);
      for (int i = dlog.size() - 1; i >= 0; i--) if (dlog[i].port == p) return dlog[i].cyc;
      return 0;
   endfunction

   // ---------------- SRAM model controls ----------------
   int unsigned a_lo = 0, a_hi = 0, d_lo = 0, d_hi = 0;
   bit          never_data = 0, inject_dok = 0, force_rd_en = 0;
   logic [31:0] force_rd = '0;
   logic        acc_wr;
   logic [3:0]  acc_ws;
   logic [31:0] acc_addr, acc_wd;

   // Behavioural SRAM: accepts the address after a random wait, answers after
   // a random data latency, and checks the request payload stays stable.
   initial begin
      bit          in_addr = 0, pend = 0, just_acc = 0;
      int unsigned acnt = 0, dcnt = 0, wa;
      logic [31:0] prd = '0, s_addr = '0, s_wd = '0;
      logic [4:0]  s_ctl = '0;
      sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = '0;
      forever begin
         @(negedge clk);
         sram_addr_ok = 1'b0;
         sram_data_ok = 1'b0;
         if (!rst) begin
            in_addr = 0; pend = 0; just_acc = 0;
            continue;
         end
         if (just_acc) begin
            chk("sram_req_drop_after_addr_ok", {31'b0, sram_req}, 32'd0);
            just_acc = 0;
         end
         if (pend) begin
            if (dcnt == 0) begin
               pend = 0; sram_data_ok = 1'b1; sram_rdata = prd;
            end else dcnt--;
         end
         if (inject_dok) begin
            sram_data_ok = 1'b1; sram_rdata = 32'hBAD0_0BAD;
         end
         if (!sram_req) in_addr = 0;
         else begin
            if (!in_addr) begin
               in_addr = 1;
               s_addr = sram_addr; s_wd = sram_wdata; s_ctl = {sram_wr, sram_wstrb};
               acnt = $urandom_range(a_hi, a_lo);
               if (!sram_wr) chk("load_wstrb_zero", {28'b0, sram_wstrb}, 32'd0);
            end else begin
               chk("addr_stable",  sram_addr, s_addr);
               chk("wdata_stable", sram_wdata, s_wd);
               chk("ctl_stable",   {27'b0, sram_wr, sram_wstrb}, {27'b0, s_ctl});
            end
            if (acnt == 0) begin
               sram_addr_ok = 1'b1;
               in_addr = 0; just_acc = 1;
               acc_wr = sram_wr; acc_ws = sram_wstrb; acc_addr = sram_addr; acc_wd = sram_wdata;
               wa = sram_addr >> 2;
               if (sram_wr) begin
                  sram_mem[wa] = merge(sram_rd(wa), sram_wdata, sram_wstrb);
                  prd = 32'hFFFF_FFFF;   // junk on the bus: writes must return 0
               end else prd = force_rd_en ? force_rd : sram_rd(wa);
               if (!never_data) begin
                  pend = 1; dcnt = $urandom_range(d_hi, d_lo);
               end
            end else acnt--;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      exp_t e;
      done_t d;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("stallreq_mem", {31'b0, stallreq_mem}, {31'b0, m0_req && !m0_done});
            chk("done_exclusive", {31'b0, m0_done && m1_done}, 32'd0);
            if (m0_done) begin
               d.port = 0; d.cyc = cyc; dlog.push_back(d);
               if (exp_q0.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL m0_unexpected_done: got done expected none (t=%0t)", $time);
               end else begin
                  e = exp_q0.pop_front();
                  chk("m0_rdata", m0_rdata, e.rdata);
                  chk("m0_err", {31'b0, m0_err}, {31'b0, e.err});
               end
            end
            if (m1_done) begin
               d.port = 1; d.cyc = cyc; dlog.push_back(d);
               if (exp_q1.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL m1_unexpected_done: got done expected none (t=%0t)", $time);
               end else begin
                  e = exp_q1.pop_front();
                  chk("m1_rdata", m1_rdata, e.rdata);
                  chk("m1_err", {31'b0, m1_err}, {31'b0, e.err});
               end
            end
         end
      end
   end

   // ---------------- requester ----------------
   // Called at posedge+1; returns at posedge+1 after the done cycle.
   task automatic do_txn(input int p, input logic wr, input logic [3:0] ws,
                         input logic [31:0] a, input logic [31:0] wd, input bit expect_to);
      exp_t        e;
      int unsigned wa = a >> 2;
      bit          got = 0;
      e.err = expect_to;
      if (expect_to || wr) e.rdata = '0;
      else                 e.rdata = force_rd_en ? force_rd : ref_rd(wa);
      if (wr && !expect_to) ref_mem[wa] = merge(ref_rd(wa), wd, ws);
      if (p == 0) begin
         exp_q0.push_back(e);
         m0_req = 1'b1; m0_wr = wr; m0_wstrb = ws; m0_addr = a; m0_wdata = wd;
      end else begin
         exp_q1.push_back(e);
         m1_req = 1'b1; m1_wr = wr; m1_wstrb = ws; m1_addr = a; m1_wdata = wd;
      end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!rst) break;
         if ((p == 0) ? m0_done : m1_done) begin
            got = 1; break;
         end
      end
      if (!rst) begin
         if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
         return;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL txn_wait port %0d: got no done, expected done within 60 cycles", p);
      end
      @(posedge clk); #1;
      if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
   endtask

   task automatic rand_port(input int p, input int n);
      logic [31:0] base = (p == 0) ? 32'h0000_1000 : 32'h0000_2000;
      int unsigned gap;
      for (int i = 0; i < n; i++) begin
         do_txn(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                base + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)), $urandom, 0);
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, expected finish before 500us");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      int unsigned st;
      int          n0;
      m0_req = 0; m0_wr = 0; m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_wr = 0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sram_ctl",  {26'b0, sram_req, sram_wr, sram_wstrb}, 32'd0);
      chk("rst_sram_addr", sram_addr, 32'd0);
      chk("rst_sram_wdata", sram_wdata, 32'd0);
      chk("rst_done_err",  {28'b0, m0_done, m0_err, m1_done, m1_err}, 32'd0);
      chk("rst_m0_rdata",  m0_rdata, 32'd0);
      chk("rst_m1_rdata",  m1_rdata, 32'd0);
      chk("rst_stall",     {31'b0, stallreq_mem}, 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // Port-0 load, data_ok after two waiting DATA cycles
      a_lo = 0; a_hi = 0; d_lo = 2; d_hi = 2;
      force_rd_en = 1; force_rd = 32'hDEAD_BEEF;
      st = cyc;
      do_txn(0, 1'b0, 4'hF, 32'h100, 32'h0, 0);
      force_rd_en = 0;
      chk("t1_latency", last_done(0) - st, 32'd5);
      chk("t1_sram_addr", acc_addr, 32'h100);
      chk("t1_sram_ctl", {27'b0, acc_wr, acc_ws}, 32'd0);

      // Port-1 store, then read it back
      d_lo = 1; d_hi = 1;
      do_txn(1, 1'b1, 4'h3, 32'h204, 32'h1234, 0);
      chk("t2_sram_ctl", {27'b0, acc_wr, acc_ws}, 32'h13);
      chk("t2_sram_addr", acc_addr, 32'h204);
      chk("t2_sram_wdata", acc_wd, 32'h1234);
      do_txn(1, 1'b0, 4'h0, 32'h204, 32'h0, 0);

      // Both ports requesting continuously from reset, zero-wait SRAM
      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      a_lo = 0; a_hi = 0; d_lo = 0; d_hi = 0;
      st = cyc; n0 = dlog.size();
      fork
         begin
            do_txn(0, 1'b0, 4'h0, 32'h1004, 32'h0, 0);
            do_txn(0, 1'b1, 4'hF, 32'h1008, 32'hA5A5_0001, 0);
         end
         begin
            do_txn(1, 1'b1, 4'h6, 32'h2008, 32'h5A5A_0002, 0);
            do_txn(1, 1'b0, 4'h0, 32'h2008, 32'h0, 0);
         end
      join
      chk("t3_done_count", 32'(dlog.size() - n0), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (n0 + i < dlog.size()) begin
            chk($sformatf("t3_port_%0d", i), 32'(dlog[n0+i].port), 32'(i % 2));
            chk($sformatf("t3_cycle_%0d", i), dlog[n0+i].cyc - st, 32'(3 + 4 * i));
         end
      end

      // Watchdog: SRAM never returns data
      never_data = 1;
      st = cyc;
      do_txn(0, 1'b0, 4'h0, 32'h1010, 32'h0, 1);
      chk("t4_abort_latency", last_done(0) - st, 32'(TO + 1));
      repeat (2) @(posedge clk);
      #1 inject_dok = 1;
      @(posedge clk);
      #1 inject_dok = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_idle_after_late_data", {29'b0, sram_req, m0_done, m1_done}, 32'd0);
      end
      never_data = 0;
      @(posedge clk); #1;
      st = cyc;
      do_txn(0, 1'b0, 4'h0, 32'h1010, 32'h0, 0);
      chk("t4_recovery_latency", last_done(0) - st, 32'd3);

      // Reset while the transaction sits in DATA
      d_lo = 6; d_hi = 6;
      fork
         do_txn(0, 1'b0, 4'h0, 32'h1020, 32'h0, 0);
         begin
            repeat (3) @(posedge clk);
            #3;
            rst = 1'b0;
            m0_req = 1'b0;
            #1;
            chk("t5_rst_ctl", {28'b0, sram_req, m0_done, m0_err, stallreq_mem}, 32'd0);
            chk("t5_rst_m0_rdata", m0_rdata, 32'd0);
            chk("t5_rst_sram_addr", sram_addr, 32'd0);
            exp_q0.delete();
         end
      join
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      d_lo = 1; d_hi = 1;
      do_txn(0, 1'b0, 4'h0, 32'h1020, 32'h0, 0);

      // addr_ok withheld for 5 cycles
      a_lo = 5; a_hi = 5; d_lo = 0; d_hi = 0;
      st = cyc;
      do_txn(1, 1'b1, 4'hC, 32'h2040, 32'hCAFE_F00D, 0);
      chk("t6_latency", last_done(1) - st, 32'd8);
      chk("t6_sram_wdata", acc_wd, 32'hCAFE_F00D);

      // Random concurrent traffic on both ports
      a_lo = 0; a_hi = 2; d_lo = 0; d_hi = 3;
      fork
         rand_port(0, 25);
         rand_port(1, 25);
      join

      repeat (5) @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
